fmc_adc_acq_capture: RTL and testbench



---
 rtl/fmc_adc_acq_pkg.sv | 16 +
 rtl/fmc_adc_acq_ram.sv | 23 ++
 rtl/fmc_adc_acq_capture.sv | 190 +++++++++++++++++++
 tb/tb_fmc_adc_acq_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fmc_adc_acq_pkg.sv
// Shared types and constants for the FMC ADC acquisition capture block.
package fmc_adc_acq_pkg;

  localparam int CH_W   = 16;
  localparam int CH_N   = 4;
  localparam int DATA_W = CH_W * CH_N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRIG,
    ST_POST,
    ST_READOUT
  } state_t;

endpackage

// File: rtl/fmc_adc_acq_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered, enable-gated read (read data holds while rd_en is low).
module fmc_adc_acq_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 64
) (
  input  logic                  sys_clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmc_adc_acq_capture.sv
// Pre/post-trigger capture into a circular buffer with streamed readout.
// Optional decimation is enabled by defining FMC_ADC_ACQ_DECIM_EN.
module fmc_adc_acq_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = fmc_adc_acq_pkg::DATA_W
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     adc_data_i,
  input  logic                  adc_valid_i,
  input  logic                  trigger_i,
  input  logic                  arm_i,
  input  logic [DEPTH_LOG2-1:0] pre_samples_i,
  input  logic [DEPTH_LOG2-1:0] post_samples_i,
`ifdef FMC_ADC_ACQ_DECIM_EN
  input  logic [7:0]            decim_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  rd_last_o
);

  import fmc_adc_acq_pkg::*;

  // Counts span 0..D inclusive, hence one extra bit over the address width.
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         DEPTH   = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  function automatic logic [CW-1:0] clamp_pre(input logic [CW-1:0] pre,
                                              input logic [CW-1:0] post);
    if (pre + post > DEPTH) return DEPTH - post;
    return pre;
  endfunction

  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  trigger_q;
  logic [CW-1:0]         pre_len;
  logic [CW-1:0]         post_len;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         beats_left;
  logic [CW-1:0]         post_arm;
  logic [CW-1:0]         pre_arm;
  logic                  capturing;
  logic                  accept;
  logic                  store;
  logic                  trig_edge;
  logic                  advance;
  logic                  rd_issue;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_W-1:0]     data_p1;

  assign post_arm  = (post_samples_i == '0) ? CNT_ONE : {1'b0, post_samples_i};
  assign pre_arm   = clamp_pre({1'b0, pre_samples_i}, post_arm);
  assign capturing = state inside {ST_PRE, ST_WAIT_TRIG, ST_POST};
  assign accept    = adc_valid_i && capturing;
  assign trig_edge = trigger_i && !trigger_q;

`ifdef FMC_ADC_ACQ_DECIM_EN
  logic [7:0] decim_len;
  logic [7:0] decim_cnt;

  // Phase 0 of the decimation counter is the stored sample, so the first
  // accepted sample after arm is always kept.
  assign store = accept && (decim_cnt == 8'd0);

  always_ff @(posedge sys_clk) begin
    if (state == ST_IDLE && arm_i) begin
      decim_len <= decim_i;
      decim_cnt <= 8'd0;
    end else if (accept) begin
      decim_cnt <= (decim_cnt == decim_len) ? 8'd0 : decim_cnt + 8'd1;
    end
  end
`else
  assign store = accept;
`endif

  // A new read is issued only when the RAM output stage is empty or will be
  // drained into the output register this cycle.
  assign advance  = !rd_valid_o || rd_ready_i;
  assign rd_issue = (state == ST_READOUT) && (beats_left != '0) && (!vld_p1 || advance);

  fmc_adc_acq_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .wr_en   (store),
    .wr_addr (wr_ptr),
    .wr_data (adc_data_i),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (data_p1)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      trigger_q  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      rd_data_o  <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      beats_left <= '0;
      cnt        <= '0;
    end else begin
      trigger_q <= trigger_i;
      done_o    <= 1'b0;
      if (store) wr_ptr <= wr_ptr + PTR_ONE;

      // p0 -> p1: RAM read issue
      if (rd_issue) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        beats_left <= beats_left - CNT_ONE;
        last_p1    <= (beats_left == CNT_ONE);
        vld_p1     <= 1'b1;
      end else if (advance) begin
        vld_p1 <= 1'b0;
      end

      // p1 -> p2: output register, held while stalled
      if (vld_p1 && advance) begin
        rd_valid_o <= 1'b1;
        rd_data_o  <= data_p1;
        rd_last_o  <= last_p1;
      end else if (rd_ready_i) begin
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (arm_i) begin
            pre_len  <= pre_arm;
            post_len <= post_arm;
            cnt      <= '0;
            busy_o   <= 1'b1;
            state    <= ST_PRE;
          end
        end
        ST_PRE: begin
          cnt <= cnt + CW'(store);
          if (cnt + CW'(store) >= pre_len) state <= ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          // The write address at the edge is the trigger sample's slot T,
          // whether it is written now or by the next stored sample.
          if (trig_edge) begin
            rd_ptr     <= wr_ptr - pre_len[DEPTH_LOG2-1:0];
            beats_left <= pre_len + post_len;
            if (store) begin
              cnt   <= CNT_ONE;
              state <= (post_len == CNT_ONE) ? ST_READOUT : ST_POST;
            end else begin
              cnt   <= '0;
              state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (store) begin
            cnt <= cnt + CNT_ONE;
            if (cnt + CNT_ONE == post_len) state <= ST_READOUT;
          end
        end
        ST_READOUT: begin
          if (rd_valid_o && rd_ready_i && rd_last_o) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_adc_acq_capture.sv
// Randomized directed bench for fmc_adc_acq_capture with a sample-list model.
module tb_fmc_adc_acq_capture;

  localparam int DL = 4;
  localparam int D  = 16;
  localparam int DW = 64;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] adc_data_i;
  logic          adc_valid_i;
  logic          trigger_i;
  logic          arm_i;
  logic [DL-1:0] pre_samples_i;
  logic [DL-1:0] post_samples_i;
`ifdef FMC_ADC_ACQ_DECIM_EN
  logic [7:0]    decim_i;
`endif
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic          rd_last_o;

  int          total = 0;
  int          bad   = 0;
  int          trig_q[$];
  logic [31:0] cap_id = 32'd0;

  always #5 sys_clk = ~sys_clk;

  fmc_adc_acq_capture #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .adc_data_i     (adc_data_i),
    .adc_valid_i    (adc_valid_i),
    .trigger_i      (trigger_i),
    .arm_i          (arm_i),
    .pre_samples_i  (pre_samples_i),
    .post_samples_i (post_samples_i),
`ifdef FMC_ADC_ACQ_DECIM_EN
    .decim_i        (decim_i),
`endif
    .busy_o         (busy_o),
    .done_o         (done_o),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .rd_last_o      (rd_last_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: number accepted samples a=0,1,.. after arm, keep every (dec+1)-th,
  // honour the first trigger seen once pre samples are stored, anchor T on the
  // first stored sample at or after it, and expect stored[T-pre .. T+post-1].
  task automatic do_capture(input int pre, input int post, input int dec,
                            input int mode, input int abort_after);
    int          post_eff, pre_eff, a, nstored, tpos, need, i, cyc, first_hs, last_hs;
    bit          trig, is_store, honoured, stall_prev, rdy;
    logic [63:0] base;
    logic [63:0] stored[$];
    logic [63:0] exp_q[$];
`ifdef FMC_ADC_ACQ_DECIM_EN
    decim_i = 8'(dec);
`else
    dec = 0;
`endif
    post_eff = (post == 0) ? 1 : post;
    pre_eff  = (pre + post_eff > D) ? D - post_eff : pre;
    need     = (abort_after > 0) ? abort_after : post_eff;
    base     = {cap_id, 32'h0};
    cap_id++;

    arm_i = 1'b1; pre_samples_i = DL'(pre); post_samples_i = DL'(post);
    adc_valid_i = 1'b0; trigger_i = 1'b0; rd_ready_i = 1'b0;
    @(negedge sys_clk);
    arm_i = 1'b0;
    chk("busy_after_arm", busy_o, 1);
    @(negedge sys_clk);

    a = 0; nstored = 0; tpos = -1; honoured = 0;
    while (a < 400 && !(tpos >= 0 && nstored >= tpos + need)) begin
      repeat ($urandom_range(0, 2)) begin
        adc_valid_i = 1'b0; trigger_i = 1'b0;
        @(negedge sys_clk);
      end
      trig = 0;
      foreach (trig_q[k]) if (trig_q[k] == a) trig = 1;
      is_store = (a % (dec + 1)) == 0;
      if (trig && !honoured && nstored >= pre_eff) honoured = 1;
      if (is_store) begin
        if (honoured && tpos < 0) tpos = nstored;
        stored.push_back(base + 64'(a));
        nstored++;
      end
      adc_valid_i = 1'b1; adc_data_i = base + 64'(a); trigger_i = trig;
      @(negedge sys_clk);
      a++;
    end
    adc_valid_i = 1'b0; trigger_i = 1'b0;
    if (abort_after > 0) return;

    for (int k = tpos - pre_eff; k < tpos + post_eff; k++) exp_q.push_back(stored[k]);

    i = 0; cyc = 0; stall_prev = 0; first_hs = -1; last_hs = -1;
    while (i < exp_q.size() && cyc < 300) begin
      if (stall_prev) chk("stall_valid", rd_valid_o, 1);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
      rd_ready_i     = rdy;
      adc_valid_i    = 1'($urandom % 2);
      adc_data_i     = {$urandom, $urandom};
      trigger_i      = 1'($urandom % 2);
      arm_i          = 1'($urandom % 2);
      pre_samples_i  = DL'($urandom);
      post_samples_i = DL'($urandom);
      if (rd_valid_o) begin
        chk("rd_data", rd_data_o, exp_q[i]);
        chk("rd_last", rd_last_o, (i == exp_q.size() - 1));
        if (rdy) begin
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          i++;
        end
      end
      stall_prev = rd_valid_o && !rdy;
      @(negedge sys_clk);
      cyc++;
    end
    arm_i = 1'b0; rd_ready_i = 1'b0; adc_valid_i = 1'b0; trigger_i = 1'b0;
    chk("beat_count", i, exp_q.size());
    if (mode == 0) chk("throughput", last_hs - first_hs, exp_q.size() - 1);
    chk("done_pulse", done_o, 1);
    chk("busy_clear", busy_o, 0);
    chk("valid_clear", rd_valid_o, 0);
    @(negedge sys_clk);
    chk("done_single", done_o, 0);
  endtask

  initial begin
    rst = 1'b1; arm_i = 1'b1; trigger_i = 1'b1; adc_valid_i = 1'b1;
    adc_data_i = '0; rd_ready_i = 1'b0; pre_samples_i = '0; post_samples_i = '0;
`ifdef FMC_ADC_ACQ_DECIM_EN
    decim_i = 8'd0;
`endif
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_last", rd_last_o, 0);
    chk("rst_data", rd_data_o, 0);
    rst = 1'b0; arm_i = 1'b0; trigger_i = 1'b0; adc_valid_i = 1'b0;
    @(negedge sys_clk);
    chk("idle_busy", busy_o, 0);

    // Basic window: beats 16..25
    trig_q = '{20};
    do_capture(4, 6, 0, 0, 0);
    // Wrap-around window: beats 29..38
    trig_q = '{33};
    do_capture(4, 6, 0, 0, 0);
    // Toggling backpressure
    trig_q = '{20};
    do_capture(4, 6, 0, 1, 0);
    // Edges in PRE and a second edge in POST are ignored
    trig_q = '{1, 3, 20, 23};
    do_capture(4, 6, 0, 2, 0);
    // pre+post > D clamps pre to D-post
    trig_q = '{30};
    do_capture(12, 8, 0, 2, 0);
    // post=0 behaves as post=1
    trig_q = '{10};
    do_capture(3, 0, 0, 0, 0);
    // pre=0
    trig_q = '{7};
    do_capture(0, 5, 0, 2, 0);

    // Reset while in POST, with arm and trigger asserted alongside
    trig_q = '{20};
    do_capture(4, 6, 0, 0, 2);
    rst = 1'b1; arm_i = 1'b1; trigger_i = 1'b1; adc_valid_i = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0; arm_i = 1'b0; trigger_i = 1'b0; adc_valid_i = 1'b0;
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_valid", rd_valid_o, 0);
    repeat (4) begin
      @(negedge sys_clk);
      chk("post_rst_no_done", done_o, 0);
    end
    trig_q = '{20};
    do_capture(4, 6, 0, 2, 0);

`ifdef FMC_ADC_ACQ_DECIM_EN
    // Every third sample stored: window 9,12,15,18,21
    trig_q = '{15};
    do_capture(2, 3, 2, 2, 0);
`endif

    for (int n = 0; n < 3; n++) begin
      int p, q;
      p = int'($urandom_range(0, 15));
      q = int'($urandom_range(0, 15));
      trig_q = '{p + int'($urandom_range(0, 12))};
      do_capture(p, q, 0, 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
